// File: rtl/tt_um_pwm_bank_pkg.sv
// PWM bank shared constants: register map, channel limit, reset values
// and the write-request bundle passed from the host port to the channels.
package tt_um_pwm_bank_pkg;

  localparam int MAX_CH = 6;

  localparam logic [2:0] ADDR_PRESC = 3'd6;
  localparam logic [2:0] ADDR_POL   = 3'd7;

  localparam logic [7:0] PRESC_RST = 8'h00;
  localparam logic [7:0] DUTY_RST  = 8'h00;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, compare against the shared
// period counter, and the registered output (optionally inverted).
module pwm_channel
  import tt_um_pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic             i_load,
  input  logic             i_pol,
  input  logic [CNT_W-1:0] i_data,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic             r_pwm;

  // Active loads the pre-write shadow, so a write on the wrap tick
  // lands one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= DUTY_RST[CNT_W-1:0];
      r_active <= DUTY_RST[CNT_W-1:0];
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) r_active <= r_shadow;
      if (i_wr)   r_shadow <= i_data;
      if (i_en)   r_pwm    <= (i_cnt < r_active) ^ i_pol;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/tt_um_pwm_bank.sv
// Multi-channel PWM bank with a strobed host write port and prescaler.
// Define PWM_POLARITY_EN to add the per-channel polarity register at addr 7.
module tt_um_pwm_bank
  import tt_um_pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic [7:0]       r_presc;
  logic [7:0]       r_pcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;

  wr_t              w_wr;
  logic             w_tick;
  logic             w_wrap;
  logic             w_presc_wr;
  logic [NUM_CH-1:0] w_pol;
  logic [NUM_CH-1:0] w_pwm;
  logic             w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], ui_in[7]};
      r_sync_d <= r_sync[1];
    end
  end

  assign w_wr = '{
    we:   ena & r_sync[1] & ~r_sync_d,
    addr: ui_in[6:4],
    data: uio_in
  };

  assign w_tick     = ena & (r_pcnt == r_presc);
  assign w_wrap     = w_tick & (r_cnt == '1);
  assign w_presc_wr = w_wr.we & (w_wr.addr == ADDR_PRESC);

  // A prescaler write restarts the divider from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= PRESC_RST;
      r_pcnt  <= 8'h00;
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else begin
      if (w_presc_wr) r_presc <= w_wr.data;
      if (w_presc_wr)  r_pcnt <= 8'h00;
      else if (w_tick) r_pcnt <= 8'h00;
      else if (ena)    r_pcnt <= r_pcnt + 8'd1;
      if (w_tick) r_cnt   <= r_cnt + 1'b1;
      if (ena)    r_start <= w_wrap;
    end
  end

`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] r_pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pol <= '0;
    end else if (w_wr.we && w_wr.addr == ADDR_POL) begin
      r_pol <= w_wr.data[NUM_CH-1:0];
    end
  end

  assign w_pol = r_pol;
`else
  assign w_pol = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (ena),
      .i_wr  (w_wr.we & (w_wr.addr == 3'(g))),
      .i_load(w_wrap),
      .i_pol (w_pol[g]),
      .i_data(w_wr.data[CNT_W-1:0]),
      .i_cnt (r_cnt),
      .o_pwm (w_pwm[g])
    );
  end

  always_comb begin
    uo_out             = 8'h00;
    uo_out[NUM_CH-1:0] = w_pwm;
    uo_out[7]          = r_start;
  end

  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign w_unused = ^ui_in[3:0];

endmodule

// File: tb/tb_tt_um_pwm_bank.sv
// Scoreboard bench for tt_um_pwm_bank: reference model predicts uo_out
// every cycle; a monitor pops and compares after each rising edge.
module tb_tt_um_pwm_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 1 << CNT_W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_pwm_bank #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];

  bit       cur_en = 1'b1;
  bit       cur_pin = 1'b0;
  int       cur_a = 0;
  int       cur_d = 0;

  // reference state
  int       m_pcnt, m_presc, m_cnt, m_pol;
  int       m_shadow[NUM_CH];
  int       m_active[NUM_CH];
  bit       h1, h2, h3;
  bit [7:0] m_out;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pcnt = 0; m_presc = 0; m_cnt = 0; m_pol = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    h1 = 0; h2 = 0; h3 = 0;
    m_out = 8'h00;
  endfunction

  // Predicts the state after the coming rising edge.
  function automatic void model_step(bit en, bit pin, int a, int d);
    bit wr, tick, wrap;
    wr   = h2 && !h3 && en;
    tick = en && (m_pcnt == m_presc);
    wrap = tick && (m_cnt == PERIOD - 1);
    if (en) begin
      for (int c = 0; c < NUM_CH; c++)
        m_out[c] = (m_cnt < m_active[c]) != (((m_pol >> c) & 1) == 1);
      m_out[7] = wrap;
    end
    if (wrap)
      for (int c = 0; c < NUM_CH; c++) m_active[c] = m_shadow[c];
    if (tick) m_cnt = (m_cnt + 1) % PERIOD;
    if (wr && a == 6) m_pcnt = 0;
    else if (tick)    m_pcnt = 0;
    else if (en)      m_pcnt = m_pcnt + 1;
    if (wr) begin
      if (a < NUM_CH) m_shadow[a] = d % PERIOD;
      else if (a == 6) m_presc = d;
`ifdef PWM_POLARITY_EN
      else if (a == 7) m_pol = d % (1 << NUM_CH);
`endif
    end
    h3 = h2; h2 = h1; h1 = pin;
  endfunction

  // Entered and left on a falling edge.
  task automatic step();
    ena    = cur_en;
    ui_in  = {cur_pin, 3'(cur_a), 4'($urandom)};
    uio_in = 8'(cur_d);
    model_step(cur_en, cur_pin, cur_a, cur_d);
    q.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    cur_pin = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(int a, int d);
    cur_a = a; cur_d = d & 8'hFF;
    cur_pin = 1'b1;
    repeat (6) step();
    cur_pin = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_uo_out", uo_out, 8'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic measure(int n, int b, output int hi, output int pulses);
    hi = 0; pulses = 0;
    repeat (n) begin
      step();
      if (uo_out[b]) hi++;
      if (uo_out[7]) pulses++;
    end
  endtask

  initial begin : monitor
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp = q.pop_front();
        chk("uo_out", uo_out, exp);
      end
      chk("uio_out", uio_out, 8'h00);
      chk("uio_oe", uio_oe, 8'h00);
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int hi, p7, sel, a, d;
    @(negedge clk);
    do_reset();
    idle(300);

    wr(6, 0);
    wr(0, 8'h40);
    idle(300);
    measure(256, 0, hi, p7);
    chk_int("ch0_high_0x40", hi, 64);
    chk_int("start_pulses_presc0", p7, 1);

    wr(6, 3);
    wr(1, 8'h80);
    idle(1100);
    measure(1024, 1, hi, p7);
    chk_int("ch1_high_presc3", hi, 512);
    chk_int("start_pulses_presc3", p7, 1);
    idle(300);
    wr(1, 8'h10);
    idle(1500);

    wr(6, 0);
    wr(2, 0);
    idle(300);
    measure(256, 2, hi, p7);
    chk_int("ch2_high_duty0", hi, 0);
    wr(2, 8'hFF);
    idle(300);
    measure(256, 2, hi, p7);
    chk_int("ch2_low_dutyFF", 256 - hi, 1);

    idle(77);
    cur_en = 1'b0;
    idle(100);
    cur_en = 1'b1;
    idle(300);

    wr(5, 8'h55);
    wr(7, 8'h01);
    wr(0, 8'h40);
    idle(300);
    measure(256, 0, hi, p7);
`ifdef PWM_POLARITY_EN
    chk_int("ch0_high_inverted", hi, 192);
`else
    chk_int("ch0_high_addr7_unmapped", hi, 64);
`endif
    idle(100);
    do_reset();
    idle(20);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        a = $urandom_range(0, 7);
        d = $urandom_range(0, 255);
        if (a == 6) d = $urandom_range(0, 3);
        wr(a, d);
      end else if (sel < 7) begin
        idle($urandom_range(1, 200));
      end else if (sel < 9) begin
        cur_en = 1'b0;
        idle($urandom_range(1, 50));
        cur_en = 1'b1;
      end else begin
        do_reset();
      end
    end
    idle(10);

    @(posedge clk);
    #2;
    chk_int("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
